// File: rtl/vga_timing_pkg.sv
// Shared raster geometry, counter width and text-grid constants for the 800x600 display path.
package vga_timing_pkg;

    localparam int CNT_W = 11;

    localparam int H_VISIBLE_DEF = 800;
    localparam int H_FP_DEF      = 56;
    localparam int H_SYNC_DEF    = 120;
    localparam int H_BP_DEF      = 64;
    localparam int V_VISIBLE_DEF = 600;
    localparam int V_FP_DEF      = 37;
    localparam int V_SYNC_DEF    = 6;
    localparam int V_BP_DEF      = 23;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int FONTHLEN = 16;
    localparam int FONTVLEN = 32;
    localparam int HCHAR    = 50;
    localparam int VCHAR    = 18;

    typedef logic [CNT_W-1:0] cnt_t;

    // True when c lies in [lo, lo+len-1].
    function automatic logic in_window(input cnt_t c, input int lo, input int len);
        return (int'(c) >= lo) && (int'(c) < lo + len);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled modulo-(MAX+1) counter; wrap is high on the enabled cycle that returns count to 0.
module wrap_counter #(
    parameter int WIDTH = 11,
    parameter int MAX   = 1039
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_reg;

    assign wrap  = en && (count_reg == WIDTH'(MAX));
    assign count = count_reg;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= wrap ? '0 : count_reg + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters with sync, visible-area flags and line/frame markers.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter bit SYNC_POL  = 1'b1
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hvalid,
    output logic             vvalid,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_geom_check
            $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2048");
        end
    endgenerate

    logic h_wrap;
    logic v_wrap;
    cnt_t hcnt_next;
    cnt_t vcnt_next;

    logic hvalid_reg;
    logic vvalid_reg;
    logic hsync_reg;
    logic vsync_reg;
    logic line_start_reg;
    logic frame_start_reg;

    wrap_counter #(
        .WIDTH (CNT_W),
        .MAX   (H_TOTAL - 1)
    ) u_hcnt (
        .clk   (clk),
        .RSTn  (RSTn),
        .en    (pix_en),
        .count (hcnt),
        .wrap  (h_wrap)
    );

    // h_wrap already includes pix_en, so it is the vertical step enable.
    wrap_counter #(
        .WIDTH (CNT_W),
        .MAX   (V_TOTAL - 1)
    ) u_vcnt (
        .clk   (clk),
        .RSTn  (RSTn),
        .en    (h_wrap),
        .count (vcnt),
        .wrap  (v_wrap)
    );

    // Values the counters will hold after an enabled step; flags decode these so they
    // land in the same clock as the counters.
    assign hcnt_next = h_wrap ? '0 : hcnt + CNT_W'(1);
    assign vcnt_next = v_wrap ? '0 : vcnt + CNT_W'(1);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            hvalid_reg      <= 1'b1;
            vvalid_reg      <= 1'b1;
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            line_start_reg  <= h_wrap;
            frame_start_reg <= v_wrap;
            if (pix_en) begin
                hvalid_reg <= int'(hcnt_next) < H_VISIBLE;
                hsync_reg  <= in_window(hcnt_next, H_VISIBLE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
            end
            if (h_wrap) begin
                vvalid_reg <= int'(vcnt_next) < V_VISIBLE;
                vsync_reg  <= in_window(vcnt_next, V_VISIBLE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign hvalid      = hvalid_reg;
    assign vvalid      = vvalid_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench: random pix_en against a linear-position raster model, default and reduced geometry.
module tb_vga_timing;

    localparam int N_CYC = 40000;
    localparam int MID_RST = 21000;

    // Reduced geometry so whole frames fit in the run; inverted sync polarity.
    localparam int SH_V = 20, SH_F = 4, SH_S = 6, SH_B = 5;
    localparam int SV_V = 10, SV_F = 2, SV_S = 3, SV_B = 2;

    logic clk = 1'b0;
    logic RSTn;
    logic pix_en;

    logic [10:0] hcnt_d, vcnt_d, hcnt_s, vcnt_s;
    logic hvalid_d, vvalid_d, hsync_d, vsync_d, ls_d, fs_d;
    logic hvalid_s, vvalid_s, hsync_s, vsync_s, ls_s, fs_s;

    always #5 clk = ~clk;

    vga_timing u_dflt (
        .clk(clk), .RSTn(RSTn), .pix_en(pix_en),
        .hcnt(hcnt_d), .vcnt(vcnt_d), .hvalid(hvalid_d), .vvalid(vvalid_d),
        .hsync(hsync_d), .vsync(vsync_d), .line_start(ls_d), .frame_start(fs_d)
    );

    vga_timing #(
        .H_VISIBLE(SH_V), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_VISIBLE(SV_V), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .RSTn(RSTn), .pix_en(pix_en),
        .hcnt(hcnt_s), .vcnt(vcnt_s), .hvalid(hvalid_s), .vvalid(vvalid_s),
        .hsync(hsync_s), .vsync(vsync_s), .line_start(ls_s), .frame_start(fs_s)
    );

    logic [27:0] got_d, got_s;
    assign got_d = {hcnt_d, vcnt_d, hvalid_d, vvalid_d, hsync_d, vsync_d, ls_d, fs_d};
    assign got_s = {hcnt_s, vcnt_s, hvalid_s, vvalid_s, hsync_s, vsync_s, ls_s, fs_s};

    typedef struct packed {
        logic [27:0] d;
        logic [27:0] s;
    } exp_t;

    exp_t sb_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int n_pushed = 0;
    int n_popped = 0;
    int exp_frames_s = 0, obs_frames_s = 0;
    int exp_lines_d = 0, obs_lines_d = 0;

    // Raster position as a single index into the frame; everything else follows from it.
    function automatic logic [27:0] model(int pos, bit stepped, int hv, int hf, int hs, int hb,
                                          int vv, int vf, int vs, int vb, bit pol);
        int ht = hv + hf + hs + hb;
        int h = pos % ht;
        int v = pos / ht;
        logic hs_act = (h >= hv + hf) && (h < hv + hf + hs);
        logic vs_act = (v >= vv + vf) && (v < vv + vf + vs);
        return {11'(h), 11'(v), logic'(h < hv), logic'(v < vv),
                hs_act ? pol : ~pol, vs_act ? pol : ~pol,
                logic'(stepped && h == 0), logic'(stepped && pos == 0)};
    endfunction

    function automatic logic [27:0] md(int pos, bit st);
        return model(pos, st, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1);
    endfunction

    function automatic logic [27:0] ms(int pos, bit st);
        return model(pos, st, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, 1'b0);
    endfunction

    task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got h=%0d v=%0d flags=%b required h=%0d v=%0d flags=%b",
                     name, $time, got[27:17], got[16:6], got[5:0], exp[27:17], exp[16:6], exp[5:0]);
        end
    endtask

    // Monitor: every clock that has a pending expectation is compared 2ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_popped++;
                check("dflt", got_d, e.d);
                check("small", got_s, e.s);
                obs_frames_s += int'(fs_s);
                obs_lines_d  += int'(ls_d);
                if (fs_s) $display("[TB] small frame %0d at t=%0t", obs_frames_s, $time);
            end
        end
    end

    localparam int TOT_D = 1040 * 666;
    localparam int TOT_S = (SH_V + SH_F + SH_S + SH_B) * (SV_V + SV_F + SV_S + SV_B);

    initial begin
        int pos_d, pos_s;
        bit force_en;
        bit pat_q[$];
        bit en;

        RSTn = 1'b0;
        pix_en = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset_dflt", got_d, md(0, 1'b0));
        check("reset_small", got_s, ms(0, 1'b0));
        $display("[TB] reset values checked");
        RSTn = 1'b1;
        pos_d = 0;
        pos_s = 0;
        force_en = 1'b1;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            if (cyc == MID_RST) begin
                #2 RSTn = 1'b0;
                #1;
                check("async_rst_dflt", got_d, md(0, 1'b0));
                check("async_rst_small", got_s, ms(0, 1'b0));
                $display("[TB] mid-frame reset applied at t=%0t", $time);
                repeat (3) @(posedge clk);
                @(negedge clk);
                RSTn = 1'b1;
                pos_d = 0;
                pos_s = 0;
                force_en = 1'b1;
                pat_q.delete();
            end

            // Hold the enable pattern 1,0,0,1 across every default-geometry line end.
            if (pat_q.size() == 0 && (pos_d % 1040) == 1038) begin
                pat_q.push_back(1'b1);
                pat_q.push_back(1'b0);
                pat_q.push_back(1'b0);
                pat_q.push_back(1'b1);
            end
            if (force_en) begin
                en = 1'b1;
                force_en = 1'b0;
            end else if (pat_q.size() > 0) begin
                en = pat_q.pop_front();
            end else begin
                en = ($urandom_range(0, 3) != 0);
            end
            pix_en = en;

            if (en) begin
                pos_d = (pos_d + 1) % TOT_D;
                pos_s = (pos_s + 1) % TOT_S;
                if (pos_s == 0) exp_frames_s++;
                if (pos_d % 1040 == 0) exp_lines_d++;
            end
            sb_q.push_back('{d: md(pos_d, en), s: ms(pos_s, en)});
            n_pushed++;
            @(negedge clk);
        end

        repeat (3) @(posedge clk);
        #3;
        n_tests++;
        if (sb_q.size() != 0 || n_popped != n_pushed) begin
            n_fail++;
            $display("FAIL drain popped=%0d required=%0d", n_popped, n_pushed);
        end
        n_tests++;
        if (obs_frames_s != exp_frames_s) begin
            n_fail++;
            $display("FAIL frame_count_small got=%0d required=%0d", obs_frames_s, exp_frames_s);
        end
        n_tests++;
        if (obs_lines_d != exp_lines_d) begin
            n_fail++;
            $display("FAIL line_count_dflt got=%0d required=%0d", obs_lines_d, exp_lines_d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
